// File: rtl/image_pixel_packer.sv
// Packs a fval/lval-qualified pixel stream four-to-a-word for the DDR3 write FIFO,
// tracking lines per frame, frame-length errors and words dropped on FIFO overflow.
module image_pixel_packer #(
  parameter int PIX_W = 10
) (
  input  logic             clk_rxg,
  input  logic             rst_rx_n,
  input  logic             fval,
  input  logic             lval,
  input  logic [PIX_W-1:0] pix_data,
  input  logic [11:0]      window_row_length,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [63:0]      fifo_din,
  output logic             frame_start,
  output logic             frame_done,
  output logic             frame_err,
  output logic [11:0]      line_cnt,
  output logic             overflow,
  input  logic             clr_overflow,
  output logic [15:0]      drop_cnt
);

  typedef enum logic [1:0] {S_ARM, S_IDLE, S_FRAME} state_t;

  logic             fv_r_q, lv_r_q, fv_dly_q, lv_dly_q;
  logic [PIX_W-1:0] pix_r_q;

  state_t      state_q, state_d;
  logic [1:0]  pix_idx_q, pix_idx_d;
  logic [63:0] word_q, word_d;
  logic [63:0] din_q, din_d;
  logic        wr_pend_q, wr_pend_d;
  logic        start_q, start_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [11:0] line_cnt_q, line_cnt_d;
  logic        ovf_q, ovf_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic accept, line_end, fv_fall, lv_fall, drop;

  function automatic logic [63:0] place_pix(input logic [63:0] w, input logic [1:0] idx,
                                            input logic [PIX_W-1:0] p);
    logic [63:0] r;
    r = w;
    r[{idx, 4'b0000} +: PIX_W] = p;
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Input stage: free-running so the reset-exit arm state sees the live fval level
  always_ff @(posedge clk_rxg) begin
    fv_r_q   <= fval;
    lv_r_q   <= lval;
    pix_r_q  <= pix_data;
    fv_dly_q <= fv_r_q;
    lv_dly_q <= lv_r_q;
  end

  assign fv_fall = fv_dly_q & ~fv_r_q;
  assign lv_fall = lv_dly_q & ~lv_r_q;

  always_comb begin
    state_d    = state_q;
    pix_idx_d  = pix_idx_q;
    word_d     = word_q;
    din_d      = din_q;
    wr_pend_d  = 1'b0;
    start_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    line_cnt_d = line_cnt_q;
    accept     = 1'b0;
    line_end   = 1'b0;

    case (state_q)
      S_ARM: begin
        if (!fv_r_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (fv_r_q) begin
          start_d    = 1'b1;
          line_cnt_d = 12'd0;
          state_d    = S_FRAME;
          accept     = lv_r_q;
        end
      end
      S_FRAME: begin
        accept   = fv_r_q & lv_r_q;
        line_end = lv_fall | (fv_fall & lv_dly_q);
        if (fv_fall) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_ARM;
    endcase

    // Pixel accept and line end are mutually exclusive: line end needs lv_r or fv_r low
    if (accept) begin
      if (pix_idx_q == 2'd3) begin
        din_d     = place_pix(word_q, pix_idx_q, pix_r_q);
        wr_pend_d = 1'b1;
        word_d    = 64'd0;
        pix_idx_d = 2'd0;
      end else begin
        word_d    = place_pix(word_q, pix_idx_q, pix_r_q);
        pix_idx_d = pix_idx_q + 2'd1;
      end
    end

    if (line_end) begin
      line_cnt_d = line_cnt_q + 12'd1;
      if (pix_idx_q != 2'd0) begin
        din_d     = word_q;
        wr_pend_d = 1'b1;
        word_d    = 64'd0;
        pix_idx_d = 2'd0;
      end
    end

    if (done_d) err_d = (line_cnt_d != window_row_length);
  end

  // Write stage: fifo_full is judged in the cycle the word is presented
  assign drop       = wr_pend_q & fifo_full;
  assign fifo_wr_en = wr_pend_q & ~fifo_full;

  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_overflow) begin
      ovf_d      = 1'b0;
      drop_cnt_d = 16'd0;
    end
    if (drop) begin
      ovf_d      = 1'b1;
      drop_cnt_d = clr_overflow ? 16'd1 : sat_inc16(drop_cnt_q);
    end
  end

  always_ff @(posedge clk_rxg) begin
    if (!rst_rx_n) begin
      state_q    <= S_ARM;
      pix_idx_q  <= 2'd0;
      word_q     <= 64'd0;
      din_q      <= 64'd0;
      wr_pend_q  <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      line_cnt_q <= 12'd0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      pix_idx_q  <= pix_idx_d;
      word_q     <= word_d;
      din_q      <= din_d;
      wr_pend_q  <= wr_pend_d;
      start_q    <= start_d;
      done_q     <= done_d;
      err_q      <= err_d;
      line_cnt_q <= line_cnt_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign fifo_din    = din_q;
  assign frame_start = start_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign line_cnt    = line_cnt_q;
  assign overflow    = ovf_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_image_pixel_packer.sv
// Directed self-checking bench for image_pixel_packer with hand-computed expectations.
module tb_image_pixel_packer;

  logic        clk_rxg = 1'b0;
  logic        rst_rx_n;
  logic        fval, lval;
  logic [9:0]  pix_data;
  logic [11:0] window_row_length;
  logic        fifo_full, clr_overflow;
  logic        fifo_wr_en;
  logic [63:0] fifo_din;
  logic        frame_start, frame_done, frame_err, overflow;
  logic [11:0] line_cnt;
  logic [15:0] drop_cnt;

  image_pixel_packer #(.PIX_W(10)) dut (
    .clk_rxg(clk_rxg), .rst_rx_n(rst_rx_n), .fval(fval), .lval(lval), .pix_data(pix_data),
    .window_row_length(window_row_length), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_din(fifo_din), .frame_start(frame_start), .frame_done(frame_done),
    .frame_err(frame_err), .line_cnt(line_cnt), .overflow(overflow),
    .clr_overflow(clr_overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk_rxg = ~clk_rxg;

  // Event log sampled on the falling edge
  logic [63:0] wr_q[$];
  int          n_start = 0, n_done = 0;
  logic        last_err = 1'b0, wr_at_done = 1'b0;
  logic [11:0] last_lc = 12'd0;

  always @(negedge clk_rxg) begin
    if (fifo_wr_en) wr_q.push_back(fifo_din);
    if (frame_start) n_start++;
    if (frame_done) begin
      n_done++;
      last_err   = frame_err;
      last_lc    = line_cnt;
      wr_at_done = fifo_wr_en;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs; returns 1 time unit after the edge that samples them
  task automatic cyc(input logic fv, input logic lv, input logic [9:0] p);
    fval = fv; lval = lv; pix_data = p;
    @(posedge clk_rxg); #1;
  endtask

  int wb, sb, db;
  logic [9:0] v;

  initial begin
    rst_rx_n = 1'b0; fval = 1'b0; lval = 1'b0; pix_data = '0;
    window_row_length = 12'd4; fifo_full = 1'b0; clr_overflow = 1'b0;
    @(posedge clk_rxg); #1;
    repeat (3) cyc(0, 0, 0);
    check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    check("rst_din", fifo_din, 64'd0);
    check("rst_line_cnt", 64'(line_cnt), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_pulses", 64'({frame_start, frame_done, frame_err}), 64'd0);
    rst_rx_n = 1'b1;
    repeat (3) cyc(0, 0, 0);

    // Nominal frame: 4 lines x 128 incrementing pixels
    wb = wr_q.size(); sb = n_start; db = n_done;
    window_row_length = 12'd4;
    cyc(1, 0, 0);
    check("start_lat_n1", 64'(frame_start), 64'd0);
    cyc(1, 0, 0);
    check("start_lat_n2", 64'(frame_start), 64'd1);
    v = 10'd0;
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 128; i++) begin
        cyc(1, 1, v);
        v = v + 10'd1;
      end
      repeat (2) cyc(1, 0, 0);
    end
    repeat (4) cyc(0, 0, 0);
    check("nom_writes", 64'(wr_q.size() - wb), 64'd128);
    check("nom_first", wr_q[wb], 64'h0003_0002_0001_0000);
    check("nom_line2", wr_q[wb + 32], 64'h0083_0082_0081_0080);
    check("nom_last", wr_q[wb + 127], 64'h01FF_01FE_01FD_01FC);
    check("nom_starts", 64'(n_start - sb), 64'd1);
    check("nom_dones", 64'(n_done - db), 64'd1);
    check("nom_lc", 64'(last_lc), 64'd4);
    check("nom_err", 64'(last_err), 64'd0);
    check("nom_lc_hold", 64'(line_cnt), 64'd4);

    // Partial word flush, then a full line to show the slot index restarted
    wb = wr_q.size(); db = n_done;
    window_row_length = 12'd2;
    repeat (2) cyc(1, 0, 0);
    cyc(1, 1, 10'h3FF); cyc(1, 1, 10'h3FE); cyc(1, 1, 10'h3FD); cyc(1, 1, 10'h3FC);
    cyc(1, 1, 10'h3FB);
    check("flush_w1_en", 64'(fifo_wr_en), 64'd1);
    check("flush_w1", fifo_din, 64'h03FC_03FD_03FE_03FF);
    cyc(1, 1, 10'h3FA);
    check("flush_gap1", 64'(fifo_wr_en), 64'd0);
    cyc(1, 0, 0);
    check("flush_gap2", 64'(fifo_wr_en), 64'd0);
    cyc(1, 0, 0);
    check("flush_w2_en", 64'(fifo_wr_en), 64'd1);
    check("flush_w2", fifo_din, 64'h0000_0000_03FA_03FB);
    cyc(1, 0, 0);
    cyc(1, 1, 10'h00A); cyc(1, 1, 10'h00B); cyc(1, 1, 10'h00C); cyc(1, 1, 10'h00D);
    repeat (2) cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 0);
    check("flush_writes", 64'(wr_q.size() - wb), 64'd3);
    check("flush_w3", wr_q[wb + 2], 64'h000D_000C_000B_000A);
    check("flush_lc", 64'(last_lc), 64'd2);
    check("flush_err", 64'(last_err), 64'd0);

    // Line count mismatch; last line ends with fval, flush coincides with frame_done
    wb = wr_q.size(); db = n_done;
    window_row_length = 12'd5;
    repeat (2) cyc(1, 0, 0);
    cyc(1, 1, 10'd1); cyc(1, 1, 10'd2); cyc(1, 0, 0);
    cyc(1, 1, 10'd3); cyc(1, 1, 10'd4); cyc(1, 0, 0);
    cyc(1, 1, 10'd5); cyc(1, 1, 10'd6);
    repeat (4) cyc(0, 0, 0);
    check("mis_dones", 64'(n_done - db), 64'd1);
    check("mis_lc", 64'(last_lc), 64'd3);
    check("mis_err", 64'(last_err), 64'd1);
    check("mis_writes", 64'(wr_q.size() - wb), 64'd3);
    check("mis_last", wr_q[wb + 2], 64'h0000_0000_0006_0005);
    check("mis_flush_at_done", 64'(wr_at_done), 64'd1);

    // Overflow: three drops, then a clear colliding with a fourth drop
    wb = wr_q.size();
    window_row_length = 12'd2;
    repeat (2) cyc(1, 0, 0);
    fifo_full = 1'b1;
    for (int i = 0; i < 12; i++) cyc(1, 1, 10'(i));
    repeat (3) cyc(1, 0, 0);
    check("ovf_writes", 64'(wr_q.size() - wb), 64'd0);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_drops", 64'(drop_cnt), 64'd3);
    cyc(1, 1, 10'd20); cyc(1, 1, 10'd21); cyc(1, 1, 10'd22); cyc(1, 1, 10'd23);
    cyc(1, 0, 0);
    check("ovf_due_no_wr", 64'(fifo_wr_en), 64'd0);
    clr_overflow = 1'b1;
    cyc(1, 0, 0);
    clr_overflow = 1'b0;
    check("ovf_clr_set_flag", 64'(overflow), 64'd1);
    check("ovf_clr_set_cnt", 64'(drop_cnt), 64'd1);
    fifo_full = 1'b0;
    repeat (4) cyc(0, 0, 0);
    check("ovf_lc", 64'(last_lc), 64'd2);
    clr_overflow = 1'b1;
    cyc(0, 0, 0);
    clr_overflow = 1'b0;
    check("ovf_clr_flag", 64'(overflow), 64'd0);
    check("ovf_clr_cnt", 64'(drop_cnt), 64'd0);

    // Reset in mid-frame: partial word discarded, frame ignored until fval re-rises
    window_row_length = 12'd1;
    repeat (2) cyc(1, 0, 0);
    cyc(1, 1, 10'h011); cyc(1, 1, 10'h022);
    wb = wr_q.size(); sb = n_start;
    rst_rx_n = 1'b0;
    repeat (2) cyc(1, 0, 0);
    check("mid_rst_lc", 64'(line_cnt), 64'd0);
    check("mid_rst_din", fifo_din, 64'd0);
    rst_rx_n = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1, 1, 10'(i + 40));
    repeat (3) cyc(1, 0, 0);
    check("mid_rst_writes", 64'(wr_q.size() - wb), 64'd0);
    check("mid_rst_starts", 64'(n_start - sb), 64'd0);
    repeat (3) cyc(0, 0, 0);
    db = n_done;
    repeat (2) cyc(1, 0, 0);
    cyc(1, 1, 10'd1); cyc(1, 1, 10'd2); cyc(1, 1, 10'd3); cyc(1, 1, 10'd4);
    repeat (2) cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 0);
    check("rearm_starts", 64'(n_start - sb), 64'd1);
    check("rearm_writes", 64'(wr_q.size() - wb), 64'd1);
    check("rearm_word", wr_q[wb], 64'h0004_0003_0002_0001);
    check("rearm_dones", 64'(n_done - db), 64'd1);
    check("rearm_err", 64'(last_err), 64'd0);

    // Stray lval with fval low
    wb = wr_q.size(); sb = n_start; db = n_done;
    for (int i = 0; i < 8; i++) cyc(0, 1, 10'(i + 100));
    repeat (4) cyc(0, 0, 0);
    check("stray_writes", 64'(wr_q.size() - wb), 64'd0);
    check("stray_lc", 64'(line_cnt), 64'd1);
    check("stray_pulses", 64'((n_start - sb) + (n_done - db)), 64'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
